dcache_ctrl_nway: RTL and testbench

Parametrised write-back, write-allocate data-cache controller for an N-way set-associative cache. It sits between the CPU memory port and the cacheline adaptor and drives the tag, valid, dirty and data arrays in the datapath. It holds per-set tree pseudo-LRU state internally. Victim selection prefers invalid ways. A full-cache flush walk writes back every dirty line on request.

---
 rtl/dcache_nway_pkg.sv | 19 +
 rtl/plru_tree.sv | 67 ++++++
 rtl/dcache_ctrl_nway.sv | 210 +++++++++++++++++++++
 tb/tb_dcache_ctrl_nway.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_nway_pkg.sv
// Shared constants for the N-way data-cache controller: FSM state codes and
// the datapath mux select encodings.
package dcache_nway_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_WB    = 3'd1;
    localparam state_t S_RB    = 3'd2;
    localparam state_t S_FSCAN = 3'd3;
    localparam state_t S_FWB   = 3'd4;

    localparam logic ADDR_CPU = 1'b0;
    localparam logic ADDR_WB  = 1'b1;

    localparam logic DIN_CPU  = 1'b0;
    localparam logic DIN_PMEM = 1'b1;

endpackage

// File: rtl/plru_tree.sv
// Per-set tree pseudo-LRU state: combinational victim lookup for one set and a
// synchronous touch-update for another.
module plru_tree #(
    parameter  int WAYS  = 4,
    parameter  int S_IDX = 3,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SETS  = 2 ** S_IDX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [S_IDX-1:0] rd_index,
    output logic [WAY_W-1:0] victim,
    input  logic             update_en,
    input  logic [S_IDX-1:0] upd_index,
    input  logic [WAY_W-1:0] upd_way
);

    localparam int NODES = WAYS - 1;
    localparam logic [WAY_W-1:0] ONE = 1;

    logic [NODES-1:0] rows [SETS];
    logic [NODES-1:0] rd_bits;
    logic [NODES-1:0] upd_bits;
    logic [NODES-1:0] upd_next;
    logic [WAY_W-1:0] rd_node;
    logic [WAY_W-1:0] upd_node;
    logic             upd_dir;

    assign rd_bits  = rows[rd_index];
    assign upd_bits = rows[upd_index];

    // Heap-ordered walk: node n has children 2n+1 (lower) and 2n+2 (upper).
    always_comb begin
        victim  = '0;
        rd_node = '0;
        for (int l = 0; l < WAY_W; l++) begin
            victim[WAY_W-1-l] = rd_bits[rd_node];
            rd_node = (rd_node << 1) + ONE + (rd_bits[rd_node] ? ONE : '0);
        end
    end

    always_comb begin
        upd_next = upd_bits;
        upd_node = '0;
        upd_dir  = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            upd_dir            = upd_way[WAY_W-1-l];
            upd_next[upd_node] = ~upd_dir;
            upd_node = (upd_node << 1) + ONE + (upd_dir ? ONE : '0);
        end
    end

    for (genvar gi = 0; gi < SETS; gi++) begin : g_set
        logic [NODES-1:0] row_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                row_reg <= '0;
            end else if (update_en && (upd_index == S_IDX'(gi))) begin
                row_reg <= upd_next;
            end
        end

        assign rows[gi] = row_reg;
    end

endmodule

// File: rtl/dcache_ctrl_nway.sv
// Write-back, write-allocate controller for an N-way set-associative data
// cache, with tree-PLRU replacement and a full-cache flush walk.
module dcache_ctrl_nway
    import dcache_nway_pkg::*;
#(
    parameter  int WAYS  = 4,
    parameter  int S_IDX = 3,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [S_IDX-1:0] set_idx,
    input  logic [WAYS-1:0]  hit_i,
    input  logic [WAYS-1:0]  valid_i,
    input  logic [WAYS-1:0]  dirty_i,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic             pmem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             flush_done,
    output logic [S_IDX-1:0] set_sel,
    output logic [WAY_W-1:0] way_sel,
    output logic             addr_sel,
    output logic             din_sel,
    output logic [WAYS-1:0]  data_we,
    output logic             we_mbe,
    output logic [WAYS-1:0]  valid_load,
    output logic [WAYS-1:0]  dirty_load,
    output logic [WAYS-1:0]  tag_load,
    output logic             valid_o,
    output logic             dirty_o
);

    state_t                   state_reg, state_next;
    logic [WAY_W-1:0]         victim_reg, victim_next;
    logic [S_IDX+WAY_W-1:0]   fcnt_reg, fcnt_next;

    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] inv_way;
    logic             inv_found;
    logic [WAY_W-1:0] plru_victim;
    logic [WAY_W-1:0] miss_victim;
    logic             plru_upd;
    logic             req;
    logic             is_write;
    logic [S_IDX-1:0] fl_set;
    logic [WAY_W-1:0] fl_way;
    logic             fl_last;

    function automatic logic [WAYS-1:0] way_onehot(input logic [WAY_W-1:0] w);
        return WAYS'(1) << w;
    endfunction

    assign req      = mem_read | mem_write;
    assign is_write = mem_write & ~mem_read;
    assign fl_set   = fcnt_reg[S_IDX+WAY_W-1:WAY_W];
    assign fl_way   = fcnt_reg[WAY_W-1:0];
    assign fl_last  = &fcnt_reg;

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_i[w]) hit_way = WAY_W'(w);
        end
    end

    // Scan downward so the lowest-index invalid way wins.
    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_i[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign miss_victim = inv_found ? inv_way : plru_victim;

    plru_tree #(
        .WAYS  (WAYS),
        .S_IDX (S_IDX)
    ) u_plru (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (set_idx),
        .victim    (plru_victim),
        .update_en (plru_upd),
        .upd_index (set_idx),
        .upd_way   (hit_way)
    );

    always_comb begin
        state_next  = state_reg;
        victim_next = victim_reg;
        fcnt_next   = fcnt_reg;
        plru_upd    = 1'b0;
        mem_resp    = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        flush_busy  = 1'b0;
        flush_done  = 1'b0;
        set_sel     = set_idx;
        way_sel     = '0;
        addr_sel    = ADDR_CPU;
        din_sel     = DIN_CPU;
        data_we     = '0;
        we_mbe      = 1'b0;
        valid_load  = '0;
        dirty_load  = '0;
        tag_load    = '0;
        valid_o     = 1'b0;
        dirty_o     = 1'b0;

        // Outputs stay at their idle values while reset is held.
        if (!rst) begin
            case (state_reg)
                S_IDLE: begin
                    if (req) begin
                        if (|hit_i) begin
                            mem_resp = 1'b1;
                            way_sel  = hit_way;
                            plru_upd = 1'b1;
                            if (is_write) begin
                                data_we    = way_onehot(hit_way);
                                we_mbe     = 1'b1;
                                din_sel    = DIN_CPU;
                                dirty_load = way_onehot(hit_way);
                                dirty_o    = 1'b1;
                            end
                        end else begin
                            victim_next = miss_victim;
                            state_next  = (valid_i[miss_victim] && dirty_i[miss_victim])
                                          ? S_WB : S_RB;
                        end
                    end else if (flush_req) begin
                        fcnt_next  = '0;
                        state_next = S_FSCAN;
                    end
                end
                S_WB: begin
                    pmem_write = 1'b1;
                    way_sel    = victim_reg;
                    addr_sel   = ADDR_WB;
                    if (pmem_resp) state_next = S_RB;
                end
                S_RB: begin
                    pmem_read  = 1'b1;
                    din_sel    = DIN_PMEM;
                    way_sel    = victim_reg;
                    data_we    = way_onehot(victim_reg);
                    valid_load = way_onehot(victim_reg);
                    dirty_load = way_onehot(victim_reg);
                    tag_load   = way_onehot(victim_reg);
                    valid_o    = 1'b1;
                    dirty_o    = 1'b0;
                    if (pmem_resp) state_next = S_IDLE;
                end
                S_FSCAN: begin
                    set_sel    = fl_set;
                    way_sel    = fl_way;
                    flush_busy = 1'b1;
                    if (valid_i[fl_way] && dirty_i[fl_way]) begin
                        state_next = S_FWB;
                    end else begin
                        // Counter wraps to zero naturally after the last slot.
                        fcnt_next = fcnt_reg + 1'b1;
                        if (fl_last) begin
                            flush_done = 1'b1;
                            state_next = S_IDLE;
                        end
                    end
                end
                S_FWB: begin
                    set_sel    = fl_set;
                    way_sel    = fl_way;
                    pmem_write = 1'b1;
                    addr_sel   = ADDR_WB;
                    flush_busy = 1'b1;
                    if (pmem_resp) begin
                        dirty_load = way_onehot(fl_way);
                        dirty_o    = 1'b0;
                        fcnt_next  = fcnt_reg + 1'b1;
                        flush_done = fl_last;
                        state_next = fl_last ? S_IDLE : S_FSCAN;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            victim_reg <= '0;
            fcnt_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            victim_reg <= victim_next;
            fcnt_reg   <= fcnt_next;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl_nway.sv
// Scoreboard bench: a 4-way/8-set controller for CPU traffic and flush, and a
// 2-way/2-set controller for the small flush walk.
module tb_dcache_ctrl_nway;

    localparam int LAT = 2;
    localparam int EV_RESP = 1, EV_PWR = 2, EV_PRD = 3, EV_FDONE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4-way, 8-set instance
    logic [2:0] set_idx, set_sel;
    logic [3:0] hit_i, valid_i, dirty_i, data_we, valid_load, dirty_load, tag_load;
    logic       mem_read, mem_write, mem_resp, pmem_resp, pmem_read, pmem_write;
    logic       flush_req, flush_busy, flush_done, addr_sel, din_sel, we_mbe, valid_o, dirty_o;
    logic [1:0] way_sel;

    // 2-way, 2-set instance
    logic [0:0] b_set_idx, b_set_sel, b_way_sel;
    logic [1:0] b_hit_i, b_valid_i, b_dirty_i, b_data_we, b_valid_load, b_dirty_load, b_tag_load;
    logic       b_mem_read, b_mem_write, b_mem_resp, b_pmem_resp, b_pmem_read, b_pmem_write;
    logic       b_flush_req, b_flush_busy, b_flush_done, b_addr_sel, b_din_sel, b_we_mbe;
    logic       b_valid_o, b_dirty_o;

    dcache_ctrl_nway #(.WAYS(4), .S_IDX(3)) u_dut (
        .clk(clk), .rst(rst), .set_idx(set_idx), .hit_i(hit_i), .valid_i(valid_i),
        .dirty_i(dirty_i), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
        .set_sel(set_sel), .way_sel(way_sel), .addr_sel(addr_sel), .din_sel(din_sel),
        .data_we(data_we), .we_mbe(we_mbe), .valid_load(valid_load), .dirty_load(dirty_load),
        .tag_load(tag_load), .valid_o(valid_o), .dirty_o(dirty_o)
    );

    dcache_ctrl_nway #(.WAYS(2), .S_IDX(1)) u_dut2 (
        .clk(clk), .rst(rst), .set_idx(b_set_idx), .hit_i(b_hit_i), .valid_i(b_valid_i),
        .dirty_i(b_dirty_i), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem_resp(b_mem_resp), .pmem_resp(b_pmem_resp), .pmem_read(b_pmem_read),
        .pmem_write(b_pmem_write), .flush_req(b_flush_req), .flush_busy(b_flush_busy),
        .flush_done(b_flush_done), .set_sel(b_set_sel), .way_sel(b_way_sel),
        .addr_sel(b_addr_sel), .din_sel(b_din_sel), .data_we(b_data_we), .we_mbe(b_we_mbe),
        .valid_load(b_valid_load), .dirty_load(b_dirty_load), .tag_load(b_tag_load),
        .valid_o(b_valid_o), .dirty_o(b_dirty_o)
    );

    // Datapath array model for the 4-way instance
    logic [7:0] tag_m [8][4];
    logic [3:0] val_m [8];
    logic [3:0] dty_m [8];
    logic [7:0] cpu_tag;

    always_comb begin
        hit_i = '0;
        for (int w = 0; w < 4; w++)
            hit_i[w] = val_m[set_sel][w] && (tag_m[set_sel][w] == cpu_tag);
        valid_i = val_m[set_sel];
        dirty_i = dty_m[set_sel];
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 8; s++) begin
                val_m[s] <= '0;
                dty_m[s] <= '0;
            end
        end else begin
            for (int w = 0; w < 4; w++) begin
                if (tag_load[w])   tag_m[set_sel][w] <= cpu_tag;
                if (valid_load[w]) val_m[set_sel][w] <= valid_o;
                if (dirty_load[w]) dty_m[set_sel][w] <= dirty_o;
            end
        end
    end

    // 2-way datapath: set 0 way 1 valid clean, set 1 way 0 valid dirty
    logic [1:0] b_val [2];
    logic [1:0] b_dty [2];

    assign b_hit_i   = 2'b00;
    assign b_valid_i = b_val[b_set_sel];
    assign b_dirty_i = b_dty[b_set_sel];

    always @(posedge clk) begin
        if (rst) begin
            b_val[0] <= 2'b10;
            b_val[1] <= 2'b01;
            b_dty[0] <= 2'b00;
            b_dty[1] <= 2'b01;
        end else begin
            for (int w = 0; w < 2; w++)
                if (b_dirty_load[w]) b_dty[b_set_sel][w] <= b_dirty_o;
        end
    end

    // Cacheline adaptors: respond LAT+2 cycles into each request
    int acnt, bcnt;
    always @(posedge clk) begin
        if (rst || pmem_resp) begin
            pmem_resp <= 1'b0;
            acnt      <= 0;
        end else if (pmem_read || pmem_write) begin
            if (acnt == LAT) pmem_resp <= 1'b1;
            else             acnt      <= acnt + 1;
        end
    end
    always @(posedge clk) begin
        if (rst || b_pmem_resp) begin
            b_pmem_resp <= 1'b0;
            bcnt        <= 0;
        end else if (b_pmem_read || b_pmem_write) begin
            if (bcnt == LAT) b_pmem_resp <= 1'b1;
            else             bcnt        <= bcnt + 1;
        end
    end

    // Observed view of whichever instance is under test
    logic sel2 = 1'b0;
    logic o_resp, o_pwr, o_prd, o_fdone, o_busy, o_presp;
    int   o_way, o_set, o_addr, o_dwe, o_mbe, o_dload, o_dout;

    always_comb begin
        if (sel2) begin
            o_resp = b_mem_resp;  o_pwr = b_pmem_write; o_prd = b_pmem_read;
            o_fdone = b_flush_done; o_busy = b_flush_busy; o_presp = b_pmem_resp;
            o_way = int'(b_way_sel); o_set = int'(b_set_sel); o_addr = int'(b_addr_sel);
            o_dwe = int'(b_data_we); o_mbe = int'(b_we_mbe); o_dload = int'(b_dirty_load);
            o_dout = int'(b_dirty_o);
        end else begin
            o_resp = mem_resp;  o_pwr = pmem_write; o_prd = pmem_read;
            o_fdone = flush_done; o_busy = flush_busy; o_presp = pmem_resp;
            o_way = int'(way_sel); o_set = int'(set_sel); o_addr = int'(addr_sel);
            o_dwe = int'(data_we); o_mbe = int'(we_mbe); o_dload = int'(dirty_load);
            o_dout = int'(dirty_o);
        end
    end

    typedef struct {
        int ev; int way; int set; int addr; int dwe; int mbe;
        int dload; int dout; int gap; int blen;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic cmpf(input string name, input int act, input int exp_v);
        if (exp_v >= 0) chk(name, act, exp_v);
    endtask

    // -1 in any field means "not compared"
    task automatic push(input int ev, input int way, input int set, input int addr,
                        input int dwe, input int mbe, input int dload, input int dout,
                        input int gap, input int blen);
        exp_t e;
        e.ev = ev; e.way = way; e.set = set; e.addr = addr; e.dwe = dwe; e.mbe = mbe;
        e.dload = dload; e.dout = dout; e.gap = gap; e.blen = blen;
        sb_q.push_back(e);
    endtask

    // Monitor: classify one event per cycle and compare against the queue head
    initial begin
        int   cyc, last_presp, blen, ev;
        bit   pp, pr;
        exp_t e;
        cyc = 0; last_presp = -100; blen = 0; pp = 0; pr = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (o_presp) last_presp = cyc;
            blen = o_busy ? blen + 1 : 0;
            ev = 0;
            if (o_resp)               ev = EV_RESP;
            else if (o_pwr && !pp)    ev = EV_PWR;
            else if (o_prd && !pr)    ev = EV_PRD;
            else if (o_fdone)         ev = EV_FDONE;
            pp = o_pwr;
            pr = o_prd;
            if (ev != 0) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_event", ev, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("event_kind", ev, e.ev);
                    cmpf("way_sel", o_way, e.way);
                    cmpf("set_sel", o_set, e.set);
                    cmpf("addr_sel", o_addr, e.addr);
                    cmpf("data_we", o_dwe, e.dwe);
                    cmpf("we_mbe", o_mbe, e.mbe);
                    cmpf("dirty_load", o_dload, e.dload);
                    cmpf("dirty_o", o_dout, e.dout);
                    if (e.gap >= 0) chk("resp_gap", cyc - last_presp, e.gap);
                    cmpf("busy_len", blen, e.blen);
                    $display("txn ev=%0d way=%0d set=%0d dwe=%0h dload=%0h busy=%0d",
                             ev, o_way, o_set, o_dwe, o_dload, blen);
                end
            end
        end
    end

    task automatic cpu_req(input int s, input int tag, input bit rd, input bit wr);
        bit done;
        done      = 1'b0;
        set_idx   = 3'(s);
        cpu_tag   = 8'(tag);
        mem_read  = rd;
        mem_write = wr;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (mem_resp) done = 1'b1;
            @(posedge clk); #1;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (!done) chk("mem_resp_timeout", 0, 1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        if (sb_q.size() != 0) chk("scoreboard_drain", sb_q.size(), 0);
    endtask

    // Miss to a clean victim followed by the refill hit
    task automatic clean_miss(input int s, input int tag, input int way);
        push(EV_PRD,  way, s, -1, 1 << way, 0, 1 << way, 0, -1, -1);
        push(EV_RESP, way, s, -1, 0, 0, 0, 0, 1, -1);
        cpu_req(s, tag, 1'b1, 1'b0);
    endtask

    task automatic read_hit(input int s, input int tag, input int way);
        push(EV_RESP, way, s, -1, 0, 0, 0, 0, -1, -1);
        cpu_req(s, tag, 1'b1, 1'b0);
    endtask

    initial begin
        bit seen;
        set_idx = 3'd5; cpu_tag = '0; mem_read = 0; mem_write = 0; flush_req = 0;
        b_set_idx = '0; b_mem_read = 0; b_mem_write = 0; b_flush_req = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_pmem_read", int'(pmem_read), 0);
        chk("rst_pmem_write", int'(pmem_write), 0);
        chk("rst_mem_resp", int'(mem_resp), 0);
        chk("rst_flush_busy", int'(flush_busy), 0);
        chk("rst_set_sel", int'(set_sel), 5);
        chk("rst_data_we", int'(data_we), 0);
        @(posedge clk); #1;

        // Empty set fills lowest invalid ways first
        clean_miss(2, 8'hA0, 0);
        clean_miss(2, 8'hB0, 1);
        clean_miss(2, 8'hC0, 2);
        clean_miss(2, 8'hD0, 3);
        read_hit(2, 8'hB0, 1);
        // PLRU now points at way 2
        clean_miss(2, 8'hE0, 2);

        push(EV_RESP, 3, 2, -1, 4'b1000, 1, 4'b1000, 1, -1, -1);
        cpu_req(2, 8'hD0, 1'b0, 1'b1);
        chk("dirty_after_write", int'(dty_m[2]), 4'b1000);

        read_hit(2, 8'hE0, 2);
        read_hit(2, 8'hB0, 1);
        // PLRU now selects dirty way 3: write back, then refill clean
        push(EV_PWR,  3, 2, 1, -1, -1, -1, -1, -1, -1);
        push(EV_PRD,  3, 2, -1, 4'b1000, 0, 4'b1000, 0, -1, -1);
        push(EV_RESP, 3, 2, -1, 0, 0, 0, 0, 1, -1);
        cpu_req(2, 8'hF0, 1'b1, 1'b0);
        chk("dirty_after_refill", int'(dty_m[2]), 0);
        chk("valid_after_refill", int'(val_m[2]), 4'b1111);

        // Read and write together behave as a read
        push(EV_RESP, 3, 2, -1, 0, 0, 0, 0, -1, -1);
        cpu_req(2, 8'hF0, 1'b1, 1'b1);
        chk("dirty_after_rdwr", int'(dty_m[2]), 0);

        // CPU request wins over flush_req; the clean flush then takes SETS*WAYS cycles
        flush_req = 1'b1;
        push(EV_RESP, 1, 2, -1, 0, 0, 0, 0, -1, -1);
        push(EV_FDONE, -1, -1, -1, -1, -1, -1, -1, -1, 32);
        cpu_req(2, 8'hB0, 1'b1, 1'b0);
        @(posedge clk); #1;
        flush_req = 1'b0;
        drain(100);

        // Small instance: one dirty line at set 1 way 0
        sel2 = 1'b1;
        push(EV_PWR, 0, 1, 1, -1, -1, -1, -1, -1, -1);
        push(EV_FDONE, -1, -1, -1, -1, -1, -1, -1, -1, 8);
        b_flush_req = 1'b1;
        @(posedge clk); #1;
        b_flush_req = 1'b0;
        drain(100);
        chk("b_dirty_cleared", int'(b_dty[1]), 0);
        chk("b_valid_kept", int'(b_val[1]), 2'b01);
        push(EV_FDONE, -1, -1, -1, -1, -1, -1, -1, -1, 4);
        b_flush_req = 1'b1;
        @(posedge clk); #1;
        b_flush_req = 1'b0;
        drain(100);
        sel2 = 1'b0;

        // Arrange PLRU so dirty way 0 is the victim, then reset mid write-back
        push(EV_RESP, 0, 2, -1, 4'b0001, 1, 4'b0001, 1, -1, -1);
        cpu_req(2, 8'hA0, 1'b0, 1'b1);
        read_hit(2, 8'hB0, 1);
        read_hit(2, 8'hF0, 3);
        push(EV_PWR, 0, 2, 1, -1, -1, -1, -1, -1, -1);
        set_idx = 3'd2; cpu_tag = 8'h11; mem_read = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (pmem_write) seen = 1'b1;
        end
        chk("wb_started", int'(seen), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wb_pmem_write", int'(pmem_write), 0);
        chk("rst_wb_pmem_read", int'(pmem_read), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_read = 1'b0;
        @(negedge clk);
        chk("post_rst_pmem_write", int'(pmem_write), 0);
        chk("post_rst_mem_resp", int'(mem_resp), 0);
        @(posedge clk); #1;
        clean_miss(2, 8'hA0, 0);

        drain(100);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d errors so far", n_errors);
        $fatal(1);
    end

endmodule
